// File: rtl/tick_scheduler_if.sv
// Grant handshake between the tick scheduler and its single shared consumer.
// The scheduler (master) presents a channel index with a valid flag; the
// consumer (slave) accepts it with a one-cycle ack.
interface tick_scheduler_if #(
  parameter int CH_W = 2
);
  logic            gnt_valid;
  logic [CH_W-1:0] gnt_ch;
  logic            gnt_ack;

  modport master (output gnt_valid, output gnt_ch, input  gnt_ack);
  modport slave  (input  gnt_valid, input  gnt_ch, output gnt_ack);
endinterface

// File: rtl/tick_scheduler.sv
// Periodic task scheduler. Each channel counts timebase ticks down from its
// programmed period and raises a pending flag on expiry. Pending channels are
// served one at a time through a round-robin valid/ack grant; an expiry that
// lands on a still-pending channel sets a sticky overrun flag.
module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH*CNT_W-1:0] i_period,
  input  logic [NUM_CH-1:0]       i_ovr_clr,
  output logic [NUM_CH-1:0]       o_pend,
  output logic [NUM_CH-1:0]       o_ovr,
  tick_scheduler_if.master        io_gnt
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_ovr;
  logic              r_gnt_valid;
  logic [CH_W-1:0]   r_gnt_ch;
  logic [CH_W-1:0]   r_last;

  logic [CNT_W-1:0]  w_reload [NUM_CH];
  logic [NUM_CH-1:0] w_expire;
  logic [NUM_CH-1:0] w_ack_clr;
  logic [CH_W-1:0]   w_sel;

  // Reload value (period minus one, a zero period behaving as one), expiry
  // detect and the one-hot pending clear produced by an accepted grant.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    w_expire  = '0;
    w_ack_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_reload[i] = (i_period[i*CNT_W +: CNT_W] == '0) ? '0
                    : i_period[i*CNT_W +: CNT_W] - 1'b1;
      w_expire[i] = i_en[i] && i_tick && (r_cnt[i] == '0);
      w_ack_clr[i] = (r_state == S_GRANT) && io_gnt.gnt_ack
                     && (r_gnt_ch == CH_W'(i));
    end
  end

  // Round-robin pick: scan offsets NUM_CH down to 1 so the smallest offset
  // after the last granted channel is the one left standing.
  always_comb begin
    w_sel = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (r_pend[(int'(r_last) + k) % NUM_CH])
        w_sel = CH_W'((int'(r_last) + k) % NUM_CH);
    end
  end

  // Per-channel countdown, pending and sticky overrun flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the counters form a small register array but each one has an
      // architectural reset value, so they are cleared here, unlike a RAM.
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: state is assigned non-blocking so every reader in this
        // clock sees the pre-edge value, independent of statement order.
        if (!i_en[i]) begin
          // A disabled channel stays armed with the current period.
          r_cnt[i]  <= w_reload[i];
          r_pend[i] <= 1'b0;
        end else if (w_expire[i]) begin
          // Expiry wins over a same-cycle ack, so the request is not lost.
          r_cnt[i]  <= w_reload[i];
          r_pend[i] <= 1'b1;
        end else begin
          if (i_tick)       r_cnt[i]  <= r_cnt[i] - 1'b1;
          if (w_ack_clr[i]) r_pend[i] <= 1'b0;
        end

        // Set has priority over the software clear.
        if (w_expire[i] && r_pend[i] && !w_ack_clr[i]) r_ovr[i] <= 1'b1;
        else if (i_ovr_clr[i])                         r_ovr[i] <= 1'b0;
      end
    end
  end

  // Grant FSM with registered valid/channel; a grant is held until acked.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gnt_valid <= 1'b0;
      r_gnt_ch    <= '0;
      r_last      <= CH_W'(NUM_CH - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend != '0) begin
            r_gnt_ch    <= w_sel;
            r_gnt_valid <= 1'b1;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (io_gnt.gnt_ack) begin
            r_last      <= r_gnt_ch;
            r_gnt_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_gnt_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign io_gnt.gnt_valid = r_gnt_valid;
  assign io_gnt.gnt_ch    = r_gnt_ch;
  assign o_pend           = r_pend;
  assign o_ovr            = r_ovr;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: a table of per-cycle vectors, hand-written
// multi-cycle sequences and a randomized run, all cross-checked every cycle
// against a schedule-based reference model.
module tb_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    tick;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH-1:0]       ovr_clr;
  logic                    ack;
  logic [NUM_CH-1:0]       pend;
  logic [NUM_CH-1:0]       ovr;

  int n_checks = 0;
  int n_errors = 0;

  tick_scheduler_if #(.CH_W(CH_W)) gnt_if ();
  assign gnt_if.gnt_ack = ack;

  tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tick    (tick),
    .i_en      (en),
    .i_period  (period),
    .i_ovr_clr (ovr_clr),
    .o_pend    (pend),
    .o_ovr     (ovr),
    .io_gnt    (gnt_if)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Expiry is scheduled on a global tick count: each channel stores the
  // tick number at which it is next due.
  int               g_ticks;
  int               due [NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_ovr;
  logic             m_valid;
  int               m_ch, m_last;

  function automatic int eff_period(int i);
    int p;
    p = int'(period[i*CNT_W +: CNT_W]);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_update();
    logic [NUM_CH-1:0] np, no;
    logic acked, hit, cl;
    int best, bestd, d;
    if (rst) begin
      g_ticks = 0;
      for (int i = 0; i < NUM_CH; i++) due[i] = 1;
      m_pend = '0; m_ovr = '0; m_valid = 1'b0; m_ch = 0; m_last = NUM_CH - 1;
    end else begin
      acked = m_valid && ack;
      if (tick) g_ticks++;
      for (int i = 0; i < NUM_CH; i++) begin
        hit = en[i] && tick && (g_ticks == due[i]);
        cl  = acked && (m_ch == i);
        if (!en[i]) begin
          due[i] = g_ticks + eff_period(i);
          np[i]  = 1'b0;
        end else if (hit) begin
          due[i] = g_ticks + eff_period(i);
          np[i]  = 1'b1;
        end else begin
          np[i]  = cl ? 1'b0 : m_pend[i];
        end
        no[i] = (hit && m_pend[i] && !cl) ? 1'b1 : (ovr_clr[i] ? 1'b0 : m_ovr[i]);
      end
      if (m_valid) begin
        if (ack) begin
          m_valid = 1'b0;
          m_last  = m_ch;
        end
      end else if (m_pend != '0) begin
        best = 0; bestd = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
          d = (i - m_last - 1 + 2 * NUM_CH) % NUM_CH;
          if (m_pend[i] && d < bestd) begin best = i; bestd = d; end
        end
        m_ch    = best;
        m_valid = 1'b1;
      end
      m_pend = np;
      m_ovr  = no;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: DUT and model consume the same inputs, outputs compared #1 later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_valid", 32'(gnt_if.gnt_valid), 32'(m_valid));
    if (m_valid) check("model_ch", 32'(gnt_if.gnt_ch), 32'(m_ch));
    check("model_pend", 32'(pend), 32'(m_pend));
    check("model_ovr", 32'(ovr), 32'(m_ovr));
  endtask

  task automatic set_period(input int i, input int v);
    period[i*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; en = '0; ack = 1'b0; ovr_clr = '0;
    step();
    rst = 1'b0;
    step();  // arming cycle with all channels disabled
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              rst;
    logic              tick;
    logic [NUM_CH-1:0] en;
    logic              ack;
    logic [NUM_CH-1:0] clr;
    logic              exp_valid;
    logic [CH_W-1:0]   exp_ch;
    logic [NUM_CH-1:0] exp_pend;
    logic [NUM_CH-1:0] exp_ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic t, logic [3:0] e, logic a, logic [3:0] c,
                              logic v, logic [1:0] ch, logic [3:0] p, logic [3:0] o);
    vec_t x;
    x.rst = r; x.tick = t; x.en = e; x.ack = a; x.clr = c;
    x.exp_valid = v; x.exp_ch = ch; x.exp_pend = p; x.exp_ovr = o;
    return x;
  endfunction

  initial begin
    logic [CH_W-1:0] grants[$];

    rst = 1'b1; tick = 1'b0; en = '0; ack = 1'b0; ovr_clr = '0;
    period = '0;
    for (int i = 0; i < NUM_CH; i++) set_period(i, 1);

    //                rst tick en    ack clr   vld ch pend  ovr
    // all channels period 1, one tick, ack held high
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 1, 4'hF, 1, 4'h0, 0, 0, 4'hF, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 1, 0, 4'hF, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 0, 4'hE, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 1, 1, 4'hE, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 0, 4'hC, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 1, 2, 4'hC, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 0, 4'h8, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 1, 3, 4'h8, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 0, 4'h0, 4'h0));
    // channel 1 only, ack withheld over three ticks, then overrun clear
    tbl.push_back(mk(0, 0, 4'h2, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 4'h0, 0, 0, 4'h2, 4'h0));
    tbl.push_back(mk(0, 0, 4'h2, 0, 4'h0, 1, 1, 4'h2, 4'h0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 4'h0, 1, 1, 4'h2, 4'h2));
    tbl.push_back(mk(0, 1, 4'h2, 0, 4'h0, 1, 1, 4'h2, 4'h2));
    tbl.push_back(mk(0, 0, 4'h2, 0, 4'h2, 1, 1, 4'h2, 4'h0));
    tbl.push_back(mk(0, 0, 4'h2, 1, 4'h0, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 0, 4'h2, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    // ack of channel 1 collides with its own expiry
    tbl.push_back(mk(0, 1, 4'h2, 0, 4'h0, 0, 0, 4'h2, 4'h0));
    tbl.push_back(mk(0, 0, 4'h2, 0, 4'h0, 1, 1, 4'h2, 4'h0));
    tbl.push_back(mk(0, 1, 4'h2, 1, 4'h0, 0, 0, 4'h2, 4'h0));
    tbl.push_back(mk(0, 0, 4'h2, 0, 4'h0, 1, 1, 4'h2, 4'h0));
    tbl.push_back(mk(0, 0, 4'h2, 1, 4'h0, 0, 0, 4'h0, 4'h0));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; tick = tbl[k].tick; en = tbl[k].en;
      ack = tbl[k].ack; ovr_clr = tbl[k].clr;
      step();
      check($sformatf("tbl%0d_valid", k), 32'(gnt_if.gnt_valid), 32'(tbl[k].exp_valid));
      if (tbl[k].exp_valid)
        check($sformatf("tbl%0d_ch", k), 32'(gnt_if.gnt_ch), 32'(tbl[k].exp_ch));
      check($sformatf("tbl%0d_pend", k), 32'(pend), 32'(tbl[k].exp_pend));
      check($sformatf("tbl%0d_ovr", k), 32'(ovr), 32'(tbl[k].exp_ovr));
    end
    ovr_clr = '0; ack = 1'b0; tick = 1'b0;

    // ---- channel 0, period 3, tick every 10 cycles, ack one cycle after valid
    set_period(0, 3);
    do_reset();
    en = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
      step();
      check($sformatf("p3_tick%0d_valid", k), 32'(gnt_if.gnt_valid), 32'(k % 3 == 0));
      if (k % 3 == 0) check($sformatf("p3_tick%0d_ch", k), 32'(gnt_if.gnt_ch), 32'd0);
      step();
      check($sformatf("p3_tick%0d_hold", k), 32'(gnt_if.gnt_valid), 32'(k % 3 == 0));
      ack = 1'b1; step(); ack = 1'b0;
      check($sformatf("p3_tick%0d_drop", k), 32'(gnt_if.gnt_valid), 32'd0);
      repeat (6) step();
      check($sformatf("p3_tick%0d_ovr", k), 32'(ovr), 32'd0);
    end

    // ---- round robin: channels 0 (period 0 -> 1) and 2 expire every tick
    set_period(0, 0); set_period(2, 1);
    do_reset();
    en = 4'b0101; ack = 1'b1; tick = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (gnt_if.gnt_valid) grants.push_back(gnt_if.gnt_ch);
    end
    ack = 1'b0; tick = 1'b0;
    check("rr_enough_grants", 32'(grants.size() >= 10), 32'd1);
    if (grants.size() > 0) check("rr_first", 32'(grants[0]), 32'd0);
    for (int j = 1; j < grants.size(); j++)
      check($sformatf("rr_alt%0d", j), 32'(grants[j]), (grants[j-1] == 0) ? 32'd2 : 32'd0);

    // ---- reset while a grant is presented with PEND=1011
    for (int i = 0; i < NUM_CH; i++) set_period(i, 1);
    do_reset();
    en = 4'b1011; tick = 1'b1; step(); tick = 1'b0;
    check("rst_pre_pend", 32'(pend), 32'hB);
    step();
    check("rst_pre_valid", 32'(gnt_if.gnt_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_valid", 32'(gnt_if.gnt_valid), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    tick = 1'b1; step(); tick = 1'b0;
    check("rst_post_pend", 32'(pend), 32'hB);
    step();
    check("rst_post_valid", 32'(gnt_if.gnt_valid), 32'd1);
    check("rst_post_ch", 32'(gnt_if.gnt_ch), 32'd0);

    // ---- randomized run against the model
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 499) == 0);
      tick = ($urandom_range(0, 2) == 0);
      ack  = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 11) == 0) en[i] = ~en[i];
        ovr_clr[i] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) set_period(i, $urandom_range(0, 4));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
